vram_cpu_port: RTL and testbench

Host-side write/read port that fills the VRAM and register file read by the tile generator. It sits directly upstream of the tile generator, which consumes the VRAM contents and base registers. Host accesses are byte-wide over two ports: data and control, in TMS9918 style. The block handles two-byte address setup, auto-increment, read-ahead buffering, register writes and arbitration handshake with the display fetch.

---
 rtl/vram_cpu_port_if.sv | 33 +++
 rtl/vram_cpu_port.sv | 171 +++++++++++++++++
 tb/tb_vram_cpu_port.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/vram_cpu_port_if.sv
// Host and VRAM bus bundle for vram_cpu_port.
// slave = the port block, master = host CPU plus display arbiter side.
interface vram_cpu_port_if #(
    parameter int ADDR_W = 14
);
    logic              cpu_wr;
    logic              cpu_rd;
    logic              cpu_mode;
    logic [7:0]        cpu_wdata;
    logic              cpu_ready;
    logic [7:0]        cpu_rdata;
    logic              cpu_rvalid;
    logic              vram_req;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_wdata;
    logic              vram_gnt;
    logic [7:0]        vram_rdata;

    modport slave (
        input  cpu_wr, cpu_rd, cpu_mode, cpu_wdata,
        input  vram_gnt, vram_rdata,
        output cpu_ready, cpu_rdata, cpu_rvalid,
        output vram_req, vram_we, vram_addr, vram_wdata
    );

    modport master (
        output cpu_wr, cpu_rd, cpu_mode, cpu_wdata,
        output vram_gnt, vram_rdata,
        input  cpu_ready, cpu_rdata, cpu_rvalid,
        input  vram_req, vram_we, vram_addr, vram_wdata
    );
endinterface

// File: rtl/vram_cpu_port.sv
// TMS9918-style host port: address setup, auto-increment, read-ahead, regs.
// Optional macro VRAM_PORT_STATUS_EN: control-port read returns status.
module vram_cpu_port #(
    parameter int ADDR_W   = 14,
    parameter int NUM_REGS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    vram_cpu_port_if.slave        bus,
    output logic [8*NUM_REGS-1:0] regs
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        CAPTURE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;

    logic [ADDR_W-1:0] addr;
    logic [7:0]        addr_tmp;
    logic              first_byte;
    logic [7:0]        read_buf;
    logic [7:0]        rdata_q;
    logic              rvalid_q;
    logic              we_q;
    logic [ADDR_W-1:0] vaddr_q;
    logic [7:0]        vwdata_q;
    logic [8*NUM_REGS-1:0] regs_q;

    logic              ready;
    logic              req;
    logic              wr_acc;
    logic              rd_acc;
    logic              commit;
    logic              ctl_second;
    logic [ADDR_W-1:0] new_addr;
    logic [7:0]        cw;

    assign cw         = bus.cpu_wdata;
    assign wr_acc     = ready & bus.cpu_wr;
    assign rd_acc     = ready & bus.cpu_rd & ~bus.cpu_wr;
    assign commit     = req & bus.vram_gnt;
    assign ctl_second = wr_acc & bus.cpu_mode & first_byte;
    assign new_addr   = ADDR_W'({cw[5:0], addr_tmp});

    assign bus.cpu_ready  = ready;
    assign bus.vram_req   = req;
    assign bus.vram_we    = we_q;
    assign bus.vram_addr  = vaddr_q;
    assign bus.vram_wdata = vwdata_q;
    assign bus.cpu_rdata  = rdata_q;
    assign bus.cpu_rvalid = rvalid_q;
    assign regs           = regs_q;

    // state register; reset kills a pending request asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // next state and handshake outputs
    always_comb begin
        state_n = state;
        ready   = 1'b0;
        req     = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (wr_acc && !bus.cpu_mode) begin
                    state_n = WAIT_GNT;
                end else if (ctl_second && cw[7:6] == 2'b00) begin
                    state_n = WAIT_GNT;
                end else if (rd_acc && !bus.cpu_mode) begin
                    state_n = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                req = 1'b1;
                if (bus.vram_gnt) begin
                    state_n = we_q ? IDLE : CAPTURE;
                end
            end
            CAPTURE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // address, read-ahead buffer, VRAM request fields and register file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr       <= '0;
            addr_tmp   <= '0;
            first_byte <= 1'b0;
            read_buf   <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            we_q       <= 1'b0;
            vaddr_q    <= '0;
            vwdata_q   <= '0;
            regs_q     <= '0;
        end else begin
            rvalid_q <= 1'b0;

            if (state == CAPTURE) begin
                read_buf <= bus.vram_rdata;
            end

            if (commit) begin
                addr <= addr + ADDR_W'(1);
            end

            if (wr_acc && bus.cpu_mode) begin
                if (!first_byte) begin
                    addr_tmp   <= cw;
                    first_byte <= 1'b1;
                end else begin
                    first_byte <= 1'b0;
                    unique case (1'b1)
                        cw[7]: begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (cw[2:0] == i[2:0]) begin
                                    regs_q[8*i +: 8] <= addr_tmp;
                                end
                            end
                        end
                        !cw[7] && cw[6]: begin
                            addr <= new_addr;
                        end
                        !cw[7] && !cw[6]: begin
                            addr    <= new_addr;
                            vaddr_q <= new_addr;
                            we_q    <= 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
            end else if (wr_acc) begin
                first_byte <= 1'b0;
                vwdata_q   <= cw;
                vaddr_q    <= addr;
                we_q       <= 1'b1;
            end else if (rd_acc && !bus.cpu_mode) begin
                first_byte <= 1'b0;
                rdata_q    <= read_buf;
                rvalid_q   <= 1'b1;
                vaddr_q    <= addr;
                we_q       <= 1'b0;
            end else if (rd_acc) begin
                rvalid_q <= 1'b1;
`ifdef VRAM_PORT_STATUS_EN
                rdata_q    <= {first_byte, state != IDLE, 6'b0};
                first_byte <= 1'b0;
`else
                rdata_q    <= 8'h00;
`endif
            end
        end
    end

endmodule

// File: tb/tb_vram_cpu_port.sv
// Directed table plus hand sequences for vram_cpu_port.
// Covers address setup, writes, regs, read-ahead, stall/wrap, reset, status.
module tb_vram_cpu_port;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk;
    logic        reset_n;
    logic [63:0] regs;
    int          total;
    int          bad;

    vram_cpu_port_if #(.ADDR_W(14)) bus ();

    vram_cpu_port #(.ADDR_W(14), .NUM_REGS(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .regs    (regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic        mode;
        logic [7:0]  wd;
        logic        gnt;
        logic        rdy;
        logic        req;
        logic        bchk;
        logic        we;
        logic [13:0] addr;
        logic [7:0]  vwd;
        logic        rv;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic wr, input logic rd,
                          input logic mode, input logic [7:0] d);
        bus.cpu_wr    = wr;
        bus.cpu_rd    = rd;
        bus.cpu_mode  = mode;
        bus.cpu_wdata = d;
        tick();
        bus.cpu_wr = 1'b0;
        bus.cpu_rd = 1'b0;
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (!bus.cpu_ready && n < 50) begin
            tick();
            n++;
        end
        chk("settle_ready", {63'd0, bus.cpu_ready}, 64'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.cpu_wr     = 1'b0;
        bus.cpu_rd     = 1'b0;
        bus.cpu_mode   = 1'b0;
        bus.cpu_wdata  = 8'h00;
        bus.vram_gnt   = 1'b1;
        bus.vram_rdata = 8'h00;
        reset_n        = 1'b0;

        tbl[0]  = '{H, L, H, 8'h34, H, H, L, L, L, 14'h0000, 8'h00, L};
        tbl[1]  = '{H, L, H, 8'h52, H, H, L, L, L, 14'h0000, 8'h00, L};
        tbl[2]  = '{H, L, L, 8'hAA, H, L, H, H, H, 14'h1234, 8'hAA, L};
        tbl[3]  = '{L, L, L, 8'h00, H, H, L, L, L, 14'h0000, 8'h00, L};
        tbl[4]  = '{H, L, L, 8'hBB, H, L, H, H, H, 14'h1235, 8'hBB, L};
        tbl[5]  = '{L, L, L, 8'h00, H, H, L, L, L, 14'h0000, 8'h00, L};
        tbl[6]  = '{H, L, L, 8'hCC, H, L, H, H, H, 14'h1236, 8'hCC, L};
        tbl[7]  = '{L, L, L, 8'h00, H, H, L, L, L, 14'h0000, 8'h00, L};
        tbl[8]  = '{H, L, H, 8'h07, H, H, L, L, L, 14'h0000, 8'h00, L};
        tbl[9]  = '{H, L, H, 8'h83, H, H, L, L, L, 14'h0000, 8'h00, L};
        tbl[10] = '{H, H, L, 8'hDD, H, L, H, H, H, 14'h1237, 8'hDD, L};
        tbl[11] = '{L, L, L, 8'h00, H, H, L, L, L, 14'h0000, 8'h00, L};

        #12;
        chk("rst_req", {63'd0, bus.vram_req}, 64'd0);
        chk("rst_regs", regs, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("rst_ready", {63'd0, bus.cpu_ready}, 64'd1);
        chk("rst_rvalid", {63'd0, bus.cpu_rvalid}, 64'd0);
        chk("rst_rdata", {56'd0, bus.cpu_rdata}, 64'd0);
        chk("rst_vaddr", {50'd0, bus.vram_addr}, 64'd0);
        chk("rst_we", {63'd0, bus.vram_we}, 64'd0);

        for (int i = 0; i < 12; i++) begin
            bus.vram_gnt = tbl[i].gnt;
            strobe(tbl[i].wr, tbl[i].rd, tbl[i].mode, tbl[i].wd);
            chk($sformatf("v%0d_ready", i),
                {63'd0, bus.cpu_ready}, {63'd0, tbl[i].rdy});
            chk($sformatf("v%0d_req", i),
                {63'd0, bus.vram_req}, {63'd0, tbl[i].req});
            chk($sformatf("v%0d_rvalid", i),
                {63'd0, bus.cpu_rvalid}, {63'd0, tbl[i].rv});
            if (tbl[i].bchk) begin
                chk($sformatf("v%0d_we", i),
                    {63'd0, bus.vram_we}, {63'd0, tbl[i].we});
                chk($sformatf("v%0d_addr", i),
                    {50'd0, bus.vram_addr}, {50'd0, tbl[i].addr});
                chk($sformatf("v%0d_wdata", i),
                    {56'd0, bus.vram_wdata}, {56'd0, tbl[i].vwd});
            end
        end
        chk("regs3", regs, 64'h00000000_07000000);

        bus.vram_gnt   = 1'b1;
        bus.vram_rdata = 8'h5A;
        strobe(H, L, H, 8'h00);
        strobe(H, L, H, 8'h00);
        chk("ra_req", {63'd0, bus.vram_req}, 64'd1);
        chk("ra_we", {63'd0, bus.vram_we}, 64'd0);
        chk("ra_addr", {50'd0, bus.vram_addr}, 64'h0);
        tick();
        chk("ra_cap_ready", {63'd0, bus.cpu_ready}, 64'd0);
        chk("ra_cap_req", {63'd0, bus.vram_req}, 64'd0);
        tick();
        chk("ra_idle", {63'd0, bus.cpu_ready}, 64'd1);
        bus.vram_gnt   = 1'b0;
        bus.vram_rdata = 8'h3C;
        strobe(L, H, L, 8'h00);
        chk("rd_rvalid", {63'd0, bus.cpu_rvalid}, 64'd1);
        chk("rd_rdata", {56'd0, bus.cpu_rdata}, 64'h5A);
        chk("rd_next_req", {63'd0, bus.vram_req}, 64'd1);
        chk("rd_next_we", {63'd0, bus.vram_we}, 64'd0);
        chk("rd_next_addr", {50'd0, bus.vram_addr}, 64'h1);
        tick();
        chk("rd_pulse", {63'd0, bus.cpu_rvalid}, 64'd0);
        bus.vram_gnt = 1'b1;
        settle();
        strobe(L, H, L, 8'h00);
        chk("rd2_rdata", {56'd0, bus.cpu_rdata}, 64'h3C);
        chk("rd2_addr", {50'd0, bus.vram_addr}, 64'h2);
        settle();

        bus.vram_gnt = 1'b0;
        strobe(H, L, H, 8'hFF);
        strobe(H, L, H, 8'h7F);
        strobe(H, L, L, 8'h11);
        bus.cpu_wr    = 1'b1;
        bus.cpu_mode  = 1'b0;
        bus.cpu_wdata = 8'h99;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("st%0d_req", c), {63'd0, bus.vram_req}, 64'd1);
            chk($sformatf("st%0d_rdy", c), {63'd0, bus.cpu_ready}, 64'd0);
            chk($sformatf("st%0d_addr", c),
                {50'd0, bus.vram_addr}, 64'h3FFF);
            chk($sformatf("st%0d_wd", c),
                {56'd0, bus.vram_wdata}, 64'h11);
        end
        bus.cpu_wr   = 1'b0;
        bus.vram_gnt = 1'b1;
        tick();
        chk("st_done_req", {63'd0, bus.vram_req}, 64'd0);
        strobe(H, L, L, 8'h22);
        chk("wrap_addr", {50'd0, bus.vram_addr}, 64'h0);
        chk("wrap_wd", {56'd0, bus.vram_wdata}, 64'h22);
        settle();

        bus.vram_gnt = 1'b0;
        strobe(H, L, L, 8'h55);
        chk("mid_req", {63'd0, bus.vram_req}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req", {63'd0, bus.vram_req}, 64'd0);
        chk("mid_rst_regs", regs, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("mid_rel_ready", {63'd0, bus.cpu_ready}, 64'd1);
        chk("mid_rel_vaddr", {50'd0, bus.vram_addr}, 64'h0);

        bus.vram_gnt = 1'b1;
        strobe(H, L, H, 8'h10);
        strobe(L, H, H, 8'h00);
        chk("stat_rvalid", {63'd0, bus.cpu_rvalid}, 64'd1);
`ifdef VRAM_PORT_STATUS_EN
        chk("stat_rdata", {56'd0, bus.cpu_rdata}, 64'h80);
        strobe(H, L, H, 8'h40);
        strobe(H, L, H, 8'h00);
        chk("stat_fb_req", {63'd0, bus.vram_req}, 64'd1);
        chk("stat_fb_addr", {50'd0, bus.vram_addr}, 64'h40);
`else
        chk("stat_rdata", {56'd0, bus.cpu_rdata}, 64'h00);
        strobe(H, L, H, 8'h40);
        chk("stat_fb_req", {63'd0, bus.vram_req}, 64'd0);
        strobe(H, L, L, 8'h66);
        chk("stat_fb_addr", {50'd0, bus.vram_addr}, 64'h10);
`endif
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
